// File: rtl/sensor_frame_pkg.sv
// Shared types for the sensor frame publisher: FSM state, frame layout,
// overrun saturation value and sequence-number width.
// Imported by sensor_frame_ctrl.
package sensor_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // cs idle, nothing pending
        ST_ARMED = 2'd1,   // cs idle, at least one sample pending
        ST_BUSY  = 2'd2    // SPI transaction active, frame frozen
    } state_t;

    // Seven signed fields plus the two "refreshed" flags. The staging copy
    // reuses the ok flags as its pend bits, so a publish is a plain copy.
    typedef struct packed {
        logic signed [15:0] quat_w;
        logic signed [15:0] quat_x;
        logic signed [15:0] quat_y;
        logic signed [15:0] quat_z;
        logic signed [15:0] gyro_x;
        logic signed [15:0] gyro_y;
        logic signed [15:0] gyro_z;
        logic               quat_ok;
        logic               gyro_ok;
    } frame_t;

    localparam logic [7:0] OVR_SAT = 8'd255;
    localparam int         SEQ_W   = 6;

    // Saturating add of up to two overwritten samples in one cycle.
    function automatic logic [7:0] ovr_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return (sum > {1'b0, OVR_SAT}) ? OVR_SAT : sum[7:0];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// 2-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses.
// Latency: sync_o follows async_i after 2 clk edges; pulses coincide with the sync_o change.
// Backpressure: none, free-running.
// Ports: clk, rst_n (async active-low), async_i (raw level), sync_o, rise_o, fall_o.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b1   // level assumed while in reset (idle level of the input)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    // [0] metastability flop, [1] synchronized value, [2] previous synchronized value
    logic [2:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= {3{RST_VAL}};
        end else begin
            sh_q <= {sh_q[1:0], async_i};
        end
    end

    assign sync_o = sh_q[1];
    assign rise_o =  sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/sensor_frame_ctrl.sv
// Stages quat/gyro samples and publishes them as one coherent frame while MCU chip select is idle.
// Latency: full pair publishes at strobe+2; lone sample publishes after TIMEOUT_CYCLES; cs_n->frozen in 3 cycles.
// Backpressure: none on the sample strobes; samples overwritten before publish are counted in overrun_cnt.
// Ports: clk, rst_n, cs_n, quat_valid/quat_*, gyro_valid/gyro_*  ->  frm_*, frm_quat_ok, frm_gyro_ok,
//        frm_seq, drdy, overrun_cnt.
// Build option: define FRAME_SEQ_EN to build the frame sequence counter; otherwise frm_seq is 0.
module sensor_frame_ctrl
    import sensor_frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096   // >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        quat_valid,
    input  logic [15:0] quat_w,
    input  logic [15:0] quat_x,
    input  logic [15:0] quat_y,
    input  logic [15:0] quat_z,
    input  logic        gyro_valid,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    output logic [15:0] frm_quat_w,
    output logic [15:0] frm_quat_x,
    output logic [15:0] frm_quat_y,
    output logic [15:0] frm_quat_z,
    output logic [15:0] frm_gyro_x,
    output logic [15:0] frm_gyro_y,
    output logic [15:0] frm_gyro_z,
    output logic        frm_quat_ok,
    output logic        frm_gyro_ok,
    output logic [5:0]  frm_seq,
    output logic        drdy,
    output logic [7:0]  overrun_cnt
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic cs_sync, cs_rise, cs_fall;

    sync_edge_det #(.RST_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (cs_n),
        .sync_o  (cs_sync),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    state_t        state_q, state_d;
    frame_t        stg_q, stg_d;     // stg_q.quat_ok / gyro_ok are the pend bits
    frame_t        frm_q, frm_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          drdy_q, drdy_d;
    logic [7:0]    ovr_q, ovr_d;
    logic          publish;

    logic pend_q, pend_g, pend_any, expired, pub_cond;
    assign pend_q   = stg_q.quat_ok;
    assign pend_g   = stg_q.gyro_ok;
    assign pend_any = pend_q | pend_g;
    assign expired  = (tmo_q == TMO_LAST);
    assign pub_cond = (pend_q & pend_g) | expired;

    // FSM: next state and the publish strobe.
    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!cs_sync) begin
                    state_d = ST_BUSY;
                end else if (pend_any | quat_valid | gyro_valid) begin
                    // arming on the strobe itself gives the strobe+2 publish from idle
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!cs_sync) begin
                    state_d = ST_BUSY;           // a starting transaction beats a publish
                end else if (pub_cond) begin
                    publish = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cs_rise) begin
                    state_d = pend_any ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: staging capture, timeout, overrun, publish copy, drdy.
    always_comb begin
        stg_d  = stg_q;
        frm_d  = frm_q;
        tmo_d  = tmo_q;
        drdy_d = drdy_q;
        ovr_d  = ovr_q;

        // Overwrite of a sample that this cycle's publish is taking is not a loss.
        ovr_d = ovr_add(ovr_q, {1'b0, quat_valid & pend_q & ~publish} +
                               {1'b0, gyro_valid & pend_g & ~publish});

        if (publish || !pend_any) begin
            tmo_d = '0;
        end else if (!expired) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (publish) begin
            frm_d         = stg_q;           // old staging contents, ok flags = pend bits
            drdy_d        = 1'b1;
            stg_d.quat_ok = 1'b0;
            stg_d.gyro_ok = 1'b0;
        end else if (cs_fall) begin
            drdy_d = 1'b0;
        end

        // Capture after the pend clear so a strobe in the publish cycle stays pending.
        if (quat_valid) begin
            stg_d.quat_w  = quat_w;
            stg_d.quat_x  = quat_x;
            stg_d.quat_y  = quat_y;
            stg_d.quat_z  = quat_z;
            stg_d.quat_ok = 1'b1;
        end
        if (gyro_valid) begin
            stg_d.gyro_x  = gyro_x;
            stg_d.gyro_y  = gyro_y;
            stg_d.gyro_z  = gyro_z;
            stg_d.gyro_ok = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stg_q   <= '0;
            frm_q   <= '0;
            tmo_q   <= '0;
            drdy_q  <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            frm_q   <= frm_d;
            tmo_q   <= tmo_d;
            drdy_q  <= drdy_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef FRAME_SEQ_EN
    logic [SEQ_W-1:0] seq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (publish) begin
            seq_q <= seq_q + SEQ_W'(1);   // wraps 63 -> 0
        end
    end

    assign frm_seq = seq_q;
`else
    assign frm_seq = 6'h0;
`endif

    assign frm_quat_w  = frm_q.quat_w;
    assign frm_quat_x  = frm_q.quat_x;
    assign frm_quat_y  = frm_q.quat_y;
    assign frm_quat_z  = frm_q.quat_z;
    assign frm_gyro_x  = frm_q.gyro_x;
    assign frm_gyro_y  = frm_q.gyro_y;
    assign frm_gyro_z  = frm_q.gyro_z;
    assign frm_quat_ok = frm_q.quat_ok;
    assign frm_gyro_ok = frm_q.gyro_ok;
    assign drdy        = drdy_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// Bench for sensor_frame_ctrl: directed scenarios with literal expectations plus randomized
// strobes and chip-select activity, all compared every cycle against a behavioural model.
module tb_sensor_frame_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        quat_valid = 1'b0, gyro_valid = 1'b0;
    logic [15:0] quat_w = '0, quat_x = '0, quat_y = '0, quat_z = '0;
    logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
    logic [15:0] frm_quat_w, frm_quat_x, frm_quat_y, frm_quat_z;
    logic [15:0] frm_gyro_x, frm_gyro_y, frm_gyro_z;
    logic        frm_quat_ok, frm_gyro_ok, drdy;
    logic [5:0]  frm_seq;
    logic [7:0]  overrun_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sensor_frame_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
        .quat_valid(quat_valid), .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
        .gyro_valid(gyro_valid), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .frm_quat_w(frm_quat_w), .frm_quat_x(frm_quat_x), .frm_quat_y(frm_quat_y), .frm_quat_z(frm_quat_z),
        .frm_gyro_x(frm_gyro_x), .frm_gyro_y(frm_gyro_y), .frm_gyro_z(frm_gyro_z),
        .frm_quat_ok(frm_quat_ok), .frm_gyro_ok(frm_gyro_ok), .frm_seq(frm_seq),
        .drdy(drdy), .overrun_cnt(overrun_cnt)
    );

    // ---------------- behavioural model ----------------
    logic [15:0] m_st[7];        // staged samples: qw qx qy qz gx gy gz
    logic [15:0] m_fr[7];        // published frame
    bit          m_pq, m_pg;     // sample waiting for publish
    bit          m_fq, m_fg;     // published ok flags
    bit          m_drdy;
    bit          m_busy;         // MCU transaction seen by the controller
    bit          m_armed;        // controller is looking for a publish opportunity
    bit          m_c1, m_c2, m_c3; // cs_n seen 1, 2, 3 edges ago
    int          m_age;          // cycles samples have waited, capped at TMO-1
    int          m_ovr;
    int          m_seq;

    task automatic m_reset();
        for (int i = 0; i < 7; i++) begin
            m_st[i] = '0;
            m_fr[i] = '0;
        end
        {m_pq, m_pg, m_fq, m_fg, m_drdy, m_busy, m_armed} = '0;
        {m_c1, m_c2, m_c3} = 3'b111;
        m_age = 0;
        m_ovr = 0;
        m_seq = 0;
    endtask

    task automatic m_step();
        bit sync, fall, rise, anyp, pub;
        int lost;
        sync = m_c2;                 // cs_n as seen through two flops
        fall = m_c3 && !m_c2;
        rise = !m_c3 && m_c2;
        anyp = m_pq || m_pg;
        pub  = 0;
        if (m_busy) begin
            if (rise) begin
                m_busy  = 0;
                m_armed = anyp;
            end
        end else if (!sync) begin
            m_busy  = 1;
            m_armed = 0;
        end else if (m_armed) begin
            if ((m_pq && m_pg) || m_age == TMO - 1) begin
                pub     = 1;
                m_armed = 0;
            end
        end else begin
            m_armed = anyp || quat_valid || gyro_valid;
        end

        if (pub || !anyp) m_age = 0;
        else if (m_age < TMO - 1) m_age = m_age + 1;

        lost = 0;
        if (quat_valid && m_pq && !pub) lost++;
        if (gyro_valid && m_pg && !pub) lost++;
        m_ovr = (m_ovr + lost > 255) ? 255 : m_ovr + lost;

        if (pub) begin
            for (int i = 0; i < 7; i++) m_fr[i] = m_st[i];
            m_fq   = m_pq;
            m_fg   = m_pg;
            m_drdy = 1;
            m_seq  = (m_seq + 1) % 64;
            m_pq   = 0;
            m_pg   = 0;
        end else if (fall) begin
            m_drdy = 0;
        end

        if (quat_valid) begin
            m_st[0] = quat_w; m_st[1] = quat_x; m_st[2] = quat_y; m_st[3] = quat_z;
            m_pq = 1;
        end
        if (gyro_valid) begin
            m_st[4] = gyro_x; m_st[5] = gyro_y; m_st[6] = gyro_z;
            m_pg = 1;
        end

        m_c3 = m_c2;
        m_c2 = m_c1;
        m_c1 = cs_n;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int exp_seq;
`ifdef FRAME_SEQ_EN
        exp_seq = m_seq;
`else
        exp_seq = 0;
`endif
        chk("mdl_quat_w", frm_quat_w, m_fr[0]);
        chk("mdl_quat_x", frm_quat_x, m_fr[1]);
        chk("mdl_quat_y", frm_quat_y, m_fr[2]);
        chk("mdl_quat_z", frm_quat_z, m_fr[3]);
        chk("mdl_gyro_x", frm_gyro_x, m_fr[4]);
        chk("mdl_gyro_y", frm_gyro_y, m_fr[5]);
        chk("mdl_gyro_z", frm_gyro_z, m_fr[6]);
        chk("mdl_quat_ok", frm_quat_ok, m_fq);
        chk("mdl_gyro_ok", frm_gyro_ok, m_fg);
        chk("mdl_drdy", drdy, m_drdy);
        chk("mdl_overrun", overrun_cnt, m_ovr);
        chk("mdl_seq", frm_seq, exp_seq);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_quat_w"}, frm_quat_w, 0);
        chk({tag, "_quat_z"}, frm_quat_z, 0);
        chk({tag, "_gyro_x"}, frm_gyro_x, 0);
        chk({tag, "_gyro_z"}, frm_gyro_z, 0);
        chk({tag, "_oks"}, {frm_quat_ok, frm_gyro_ok}, 0);
        chk({tag, "_seq"}, frm_seq, 0);
        chk({tag, "_drdy"}, drdy, 0);
        chk({tag, "_overrun"}, overrun_cnt, 0);
    endtask

    // One clock: compare on the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One-cycle strobe; quat fields base+0..3, gyro fields base+8..10.
    task automatic strobe(input bit q, input bit g, input logic [15:0] base);
        quat_w = base;      quat_x = base + 1;  quat_y = base + 2;  quat_z = base + 3;
        gyro_x = base + 8;  gyro_y = base + 9;  gyro_z = base + 10;
        quat_valid = q;
        gyro_valid = g;
        tick();
        quat_valid = 0;
        gyro_valid = 0;
    endtask

    int cs_cnt;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1;
        ticks(3);

        // Full pair, gyro 5 cycles after quat: publish visible at gyro strobe + 2.
        strobe(1, 0, 16'h1000);
        ticks(4);
        strobe(0, 1, 16'h2000);
        chk("pair_drdy_early", drdy, 0);
        tick();
        chk("pair_quat_w", frm_quat_w, 16'h1000);
        chk("pair_quat_z", frm_quat_z, 16'h1003);
        chk("pair_gyro_x", frm_gyro_x, 16'h2008);
        chk("pair_gyro_z", frm_gyro_z, 16'h200a);
        chk("pair_oks", {frm_quat_ok, frm_gyro_ok}, 2'b11);
        chk("pair_drdy", drdy, 1);
`ifdef FRAME_SEQ_EN
        chk("pair_seq", frm_seq, 1);
`else
        chk("pair_seq", frm_seq, 0);
`endif

        // Lone quat: partial publish after the timeout, gyro fields untouched.
        ticks(5);
        strobe(1, 0, 16'h3000);
        ticks(15);
        chk("tmo_not_yet", frm_quat_w, 16'h1000);
        tick();
        chk("tmo_quat_w", frm_quat_w, 16'h3000);
        chk("tmo_oks", {frm_quat_ok, frm_gyro_ok}, 2'b10);
        chk("tmo_gyro_kept", frm_gyro_x, 16'h2008);

        // Transaction: frame frozen, drdy drops 3 cycles after cs_n falls.
        ticks(3);
        cs_n = 0;
        ticks(2);
        chk("cs_drdy_held", drdy, 1);
        tick();
        chk("cs_drdy_drop", drdy, 0);
        ticks(2);
        strobe(1, 1, 16'h4000);
        ticks(2);
        strobe(1, 1, 16'h5000);
        ticks(3);
        chk("cs_frozen", frm_quat_w, 16'h3000);
        cs_n = 1;
        ticks(3);
        chk("cs_frozen_rise", frm_quat_w, 16'h3000);
        tick();
        chk("cs_pub_quat_w", frm_quat_w, 16'h5000);
        chk("cs_pub_gyro_z", frm_gyro_z, 16'h500a);
        chk("cs_overrun", overrun_cnt, 2);
        chk("cs_pub_drdy", drdy, 1);

        // 300 quat strobes during a transaction saturate the overrun counter.
        ticks(5);
        cs_n = 0;
        ticks(4);
        for (int i = 0; i < 300; i++) strobe(1, 0, 16'(i));
        tick();
        chk("ovr_sat", overrun_cnt, 255);
        cs_n = 1;
        ticks(40);

        // Gyro strobe in the publish cycle stays pending and publishes after timeout.
        strobe(1, 1, 16'h6000);
        strobe(0, 1, 16'h7000);
        chk("coll_gyro_old", frm_gyro_x, 16'h6008);
        chk("coll_quat", frm_quat_w, 16'h6000);
        ticks(15);
        chk("coll_wait", frm_gyro_x, 16'h6008);
        tick();
        chk("coll_gyro_new", frm_gyro_x, 16'h7008);
        chk("coll_oks", {frm_quat_ok, frm_gyro_ok}, 2'b01);

        // Reset during a transaction with drdy set: outputs clear at once.
        ticks(3);
        strobe(1, 1, 16'h1111);
        tick();
        chk("rst_pre_drdy", drdy, 1);
        cs_n = 0;
        tick();
        #2 rst_n = 0;
        #1 check_zero("rst_mid");
        ticks(3);
        cs_n = 1;
        rst_n = 1;
        ticks(3);

        // 64 publishes from a fresh reset wrap the sequence number.
        for (int i = 0; i < 64; i++) begin
            strobe(1, 1, 16'(i * 16));
            tick();
            tick();
`ifdef FRAME_SEQ_EN
            if (i == 62) chk("seq_63", frm_seq, 63);
`endif
        end
        chk("seq_wrap", frm_seq, 0);
        chk("seq_last_frame", frm_quat_w, 16'h03f0);
        chk("seq_no_overrun", overrun_cnt, 0);

        // Randomized strobes, data and chip-select activity.
        cs_cnt = 10;
        for (int c = 0; c < 2500; c++) begin
            if (cs_cnt == 0) begin
                cs_n = ~cs_n;
                cs_cnt = cs_n ? int'($urandom_range(3, 60)) : int'($urandom_range(1, 30));
            end else begin
                cs_cnt--;
            end
            quat_w = 16'($urandom); quat_x = 16'($urandom);
            quat_y = 16'($urandom); quat_z = 16'($urandom);
            gyro_x = 16'($urandom); gyro_y = 16'($urandom); gyro_z = 16'($urandom);
            quat_valid = ($urandom_range(0, 99) < 12);
            gyro_valid = ($urandom_range(0, 99) < 12);
            tick();
        end
        quat_valid = 0;
        gyro_valid = 0;
        cs_n = 1;
        ticks(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_frame_ctrl.md
# sensor_frame_ctrl

- Publishes a stable, coherent sensor frame to the MCU SPI slave and tells the MCU when a new frame is ready.
- Sits between the BNO085 controller outputs and the read-only SPI slave.
- Collects quaternion and gyro samples into staging registers, then copies them into an output frame.
- Copies happen only while chip select is idle, so no SPI transaction ever sees a frame that changes mid-read.
- Drives a data-ready line to the MCU, a saturating overrun counter and an optional frame sequence number.

## Interface
- TIMEOUT_CYCLES, 4096: cycles to wait for the partner sample after the first sample arrives, before publishing a partial frame (≥2).
- clk  input  1  FPGA system clock.
- rst_n  input  1  Asynchronous active-low reset; all state clears immediately.
- cs_n  input  1  Raw MCU chip select (active low, asynchronous to clk).
- quat_valid  input  1  One-cycle strobe: quat_w/x/y/z valid.
- quat_w, quat_x, quat_y, quat_z  input  16 each  Signed quaternion components.
- gyro_valid  input  1  One-cycle strobe: gyro_x/y/z valid.
- gyro_x, gyro_y, gyro_z  input  16 each  Signed gyro components.
- frm_quat_w/x/y/z, frm_gyro_x/y/z  output  16 each  Published frame fields, fed to the SPI slave.
- frm_quat_ok, frm_gyro_ok  output  1  Published flags: field was refreshed in this frame.
- frm_seq  output  6  Frame sequence number (flags byte bits 7:2).
- drdy  output  1  Data-ready to the MCU, level, active high.
- overrun_cnt  output  8  Saturating count of samples overwritten before publish.

## Operation
- cs_n passes through a 2-flop synchronizer; cs_fall and cs_rise are one-cycle edge pulses derived from the synchronized value.
- Staging capture:
  - quat_valid loads the quat staging registers and sets pend_q.
  - gyro_valid loads the gyro staging registers and sets pend_g.
  - Capture happens in every state.
  - If a strobe arrives while its pend bit is already set, the new data overwrites the old and overrun_cnt increments, saturating at 255.
- Timeout counter:
  - Clears while pend_q and pend_g are both 0.
  - Otherwise increments each cycle, saturating.
  - Expired means count == TIMEOUT_CYCLES-1.
- States:
  - IDLE: cs idle, nothing pending. Any pend bit set -> ARMED. cs_sync low -> BUSY.
  - ARMED: cs idle, samples pending. Publish condition (pend_q & pend_g, or timeout expired) -> publish, -> IDLE. cs_sync low -> BUSY, with no publish.
  - BUSY: transaction active, frame frozen. cs_rise -> ARMED if any pend bit is set, else IDLE.
- Publish (one cycle):
  - Copy staging to frm_*.
  - frm_quat_ok = pend_q, frm_gyro_ok = pend_g.
  - Clear both pend bits and the timeout counter.
  - Set drdy; increment frm_seq, wrapping 63 -> 0.
- drdy clears on cs_fall. It is not cleared by a later publish; an unread frame is simply replaced.
- Simultaneous events:
  - Strobe in the publish cycle: the publish takes the old staging contents; the new sample is captured and its pend bit ends set (set wins over clear).
  - cs_fall in the publish cycle: BUSY wins and no publish occurs.
  - cs_rise and a publish condition in the same cycle: return to ARMED; the publish happens on the next cycle.

## Timing
- Reset values:
  - All frm_* fields 0, both ok flags 0, frm_seq 0, drdy 0, overrun_cnt 0.
  - Staging registers, pend bits and timeout counter 0; state IDLE.
- Latency, both pend bits set while ARMED: the publish condition is evaluated the cycle after the second strobe, and frm_*/drdy update one cycle after that (strobe +2 cycles).
- Latency, from IDLE: the first strobe moves the state to ARMED on the next edge, so a second strobe arriving in the same cycle as the first publishes at strobe +2.
- cs_n to BUSY: 2 synchronizer cycles plus 1 state cycle. The SPI slave samples frm_* only after its own synchronized CS falls, so the frame is frozen before the first SCK edge.
- Partial publish: TIMEOUT_CYCLES cycles after the first pending strobe, assuming cs stays idle.
- Reset asserted mid-transaction: outputs return to reset values immediately and drdy drops.

## Configuration
- FRAME_SEQ_EN defined: frm_seq counts publishes as described.
- FRAME_SEQ_EN undefined: the counter is not built, frm_seq is tied to 6'h0, and the flags byte is unchanged from the legacy format.

## Structure
- Package sensor_frame_pkg holds:
  - the state enum typedef;
  - the frame struct typedef (seven signed 16-bit fields plus two ok flags);
  - localparams for the overrun saturation value and the sequence width.
- One sub-module: sync_edge_det, a 2-flop synchronizer with rise/fall pulse outputs and async active-low reset. Instantiated once for cs_n.

## Test plan
- Reset release, quat then gyro strobes 5 cycles apart, cs_n high -> publish at gyro +2 cycles; frm values match; both ok flags 1; drdy=1; frm_seq=1.
- Quat strobe only, TIMEOUT_CYCLES=16 -> publish 16 cycles later with frm_quat_ok=1, frm_gyro_ok=0, gyro fields unchanged.
- cs_n low, two full sample pairs arrive during the transaction -> frm_* unchanged until cs_n rises; drdy drops 3 cycles after cs_n falls; on cs_rise the second pair publishes and overrun_cnt=2.
- 300 quat strobes with cs_n held low -> overrun_cnt saturates at 255.
- Gyro strobe in the publish cycle -> the frame holds the older gyro sample, pend_g stays set, and a second publish follows after timeout; 64 publishes wrap frm_seq to 0 (FRAME_SEQ_EN defined) or leave it at 0 (undefined).
- rst_n asserted mid-BUSY with drdy=1 -> all outputs 0 in the same cycle; normal operation resumes after release.
